// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   arb_state_e            : arbiter FSM state encoding
//   REQ_FETCH / REQ_DATA   : requester IDs (instruction fetch = 0, load/store = 1)
//   DEFAULT_TIMEOUT_CYCLES : default RESP-state wait limit for memory ready
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between the fetch and data requesters, plus the
// round-robin pointer (ID of the requester granted last).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> on a tie, grant the requester not granted last
//   undefined -> on a tie, the data requester always wins
// Ports:
//   clk_i, rst_ni       : clock, async active-low reset
//   fetch_req_i         : fetch requester request level
//   data_req_i          : data requester request level
//   grant_en_i          : a grant is being taken this cycle (updates pointer)
//   grant_valid_c_o     : combinational, at least one request present
//   grant_id_c_o        : combinational, ID of the selected requester
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic grant_en_i,
    output logic grant_valid_c_o,
    output logic grant_id_c_o
);

    logic last_q;
    logic last_d;

    // Requester selection
    always_comb begin
        grant_valid_c_o = fetch_req_i | data_req_i;
        grant_id_c_o    = REQ_FETCH;
        if (fetch_req_i && data_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id_c_o = ~last_q;
`else
            grant_id_c_o = REQ_DATA;
`endif
        end else if (data_req_i) begin
            grant_id_c_o = REQ_DATA;
        end
    end

    // Pointer follows every grant, contended or not
    always_comb begin
        last_d = last_q;
        if (grant_en_i) begin
            last_d = grant_id_c_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_FETCH;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) single-port memory arbiter.
// One access at a time: IDLE -> ISSUE -> RESP -> DONE, all outputs registered.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break,
// implemented in mem_arb_grant; default build gives data priority).
// Ports:
//   i_CLK, i_RST_N                          : clock, async active-low reset
//   i_fetch_req, i_fetch_addr               : fetch read request (requester 0)
//   o_fetch_data, o_fetch_ack               : fetch read data, completion pulse
//   i_data_req, i_data_we, i_data_addr,
//   i_data_wdata                            : load/store request (requester 1)
//   o_data_rdata, o_data_ack                : load data, completion pulse
//   o_mem_read_en, o_mem_write_en           : one-cycle memory enables
//   o_mem_read_addr, o_mem_write_addr,
//   o_mem_write_data                        : memory address / write data
//   i_mem_read_data, i_mem_ready            : memory read data and ready
//   o_timeout                               : sticky memory-timeout flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddrBusSize   = 16,
    parameter int unsigned ElementSize   = 16,
    parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   i_CLK,
    input  logic                   i_RST_N,
    input  logic                   i_fetch_req,
    input  logic [AddrBusSize-1:0] i_fetch_addr,
    output logic [ElementSize-1:0] o_fetch_data,
    output logic                   o_fetch_ack,
    input  logic                   i_data_req,
    input  logic                   i_data_we,
    input  logic [AddrBusSize-1:0] i_data_addr,
    input  logic [ElementSize-1:0] i_data_wdata,
    output logic [ElementSize-1:0] o_data_rdata,
    output logic                   o_data_ack,
    output logic                   o_mem_write_en,
    output logic                   o_mem_read_en,
    output logic [AddrBusSize-1:0] o_mem_write_addr,
    output logic [AddrBusSize-1:0] o_mem_read_addr,
    output logic [ElementSize-1:0] o_mem_write_data,
    input  logic [ElementSize-1:0] i_mem_read_data,
    input  logic                   i_mem_ready,
    output logic                   o_timeout
);

    // Counter holds 0 .. TimeoutCycles-1
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    arb_state_e             state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic                   we_q, we_d;
    logic [AddrBusSize-1:0] addr_q, addr_d;
    logic [ElementSize-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   fetch_ack_q, fetch_ack_d;
    logic                   data_ack_q, data_ack_d;
    logic [ElementSize-1:0] fetch_data_q, fetch_data_d;
    logic [ElementSize-1:0] data_rdata_q, data_rdata_d;
    logic                   timeout_q, timeout_d;

    logic grant_en_c;
    logic grant_valid_c;
    logic grant_id_c;

    mem_arb_grant u_grant (
        .clk_i           (i_CLK),
        .rst_ni          (i_RST_N),
        .fetch_req_i     (i_fetch_req),
        .data_req_i      (i_data_req),
        .grant_en_i      (grant_en_c),
        .grant_valid_c_o (grant_valid_c),
        .grant_id_c_o    (grant_id_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        timeout_d    = timeout_q;
        grant_en_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    grant_en_c = 1'b1;
                    gnt_d      = grant_id_c;
                    if (grant_id_c == REQ_DATA) begin
                        we_d    = i_data_we;
                        addr_d  = i_data_addr;
                        rd_en_d = ~i_data_we;
                        wr_en_d = i_data_we;
                        if (i_data_we) begin
                            wdata_d = i_data_wdata;
                        end
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = i_fetch_addr;
                        rd_en_d = 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (i_mem_ready) begin
                    if (!we_q) begin
                        if (gnt_q == REQ_DATA) begin
                            data_rdata_d = i_mem_read_data;
                        end else begin
                            fetch_data_d = i_mem_read_data;
                        end
                    end
                    fetch_ack_d = (gnt_q == REQ_FETCH);
                    data_ack_d  = (gnt_q == REQ_DATA);
                    state_d     = ST_DONE;
                end else if (cnt_q == CntLast) begin
                    // Memory never answered: complete with zero read data
                    timeout_d = 1'b1;
                    if (!we_q) begin
                        if (gnt_q == REQ_DATA) begin
                            data_rdata_d = '0;
                        end else begin
                            fetch_data_d = '0;
                        end
                    end
                    fetch_ack_d = (gnt_q == REQ_FETCH);
                    data_ack_d  = (gnt_q == REQ_DATA);
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q      <= ST_IDLE;
            gnt_q        <= REQ_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_fetch_data     = fetch_data_q;
    assign o_fetch_ack      = fetch_ack_q;
    assign o_data_rdata     = data_rdata_q;
    assign o_data_ack       = data_ack_q;
    assign o_mem_read_en    = rd_en_q;
    assign o_mem_write_en   = wr_en_q;
    assign o_mem_read_addr  = addr_q;
    assign o_mem_write_addr = addr_q;
    assign o_mem_write_data = wdata_q;
    assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// accesses, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_data;
    logic          fetch_ack;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          data_ack;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [AW-1:0] mem_write_addr;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          timeout;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AddrBusSize(AW), .ElementSize(DW), .TimeoutCycles(15)) dut (
        .i_CLK            (clk),
        .i_RST_N          (rst_n),
        .i_fetch_req      (fetch_req),
        .i_fetch_addr     (fetch_addr),
        .o_fetch_data     (fetch_data),
        .o_fetch_ack      (fetch_ack),
        .i_data_req       (data_req),
        .i_data_we        (data_we),
        .i_data_addr      (data_addr),
        .i_data_wdata     (data_wdata),
        .o_data_rdata     (data_rdata),
        .o_data_ack       (data_ack),
        .o_mem_write_en   (mem_write_en),
        .o_mem_read_en    (mem_read_en),
        .o_mem_write_addr (mem_write_addr),
        .o_mem_read_addr  (mem_read_addr),
        .o_mem_write_data (mem_write_data),
        .i_mem_read_data  (mem_rdata),
        .i_mem_ready      (mem_ready),
        .o_timeout        (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory responder: stores what the DUT writes; raises ready rsp_delay
    // cycles after an enable (rsp_delay 0 = never answers).
    logic [DW-1:0] mem_store [logic [AW-1:0]];
    int            rsp_delay = 1;
    int            rsp_cnt = 0;
    logic [AW-1:0] rsp_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_cnt   = 0;
            mem_ready = 1'b0;
        end else if (mem_read_en || mem_write_en) begin
            rsp_addr = mem_read_addr;
            if (mem_write_en) mem_store[mem_write_addr] = mem_write_data;
            rsp_cnt   = rsp_delay;
            mem_ready = 1'b0;
        end else if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_store.exists(rsp_addr) ? mem_store[rsp_addr] : mem_default(rsp_addr);
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_fdata = '0;
    logic [DW-1:0] exp_drdata = '0;
    bit            exp_tmo = 1'b0;
    bit            last_gnt = 1'b0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one access from the currently held requests; call with the DUT
    // idle just after a negedge. Returns which requester the DUT acked.
    task automatic serve(input int delay, input bit keep, output bit got_data);
        bit            win;
        bit            we;
        bit            timed_out;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            k;
        int            exp_k;

        if (fetch_req && data_req) win = RR ? ~last_gnt : 1'b1;
        else                       win = data_req;
        last_gnt  = win;
        we        = win ? data_we : 1'b0;
        a         = win ? data_addr : fetch_addr;
        wd        = data_wdata;
        timed_out = (delay == 0) || (delay > 15);
        exp_k     = timed_out ? 16 : delay + 1;
        rsp_delay = delay;

        @(negedge clk);
        chk("issue_rd_en", 32'(mem_read_en), 32'(!we));
        chk("issue_wr_en", 32'(mem_write_en), 32'(we));
        chk("issue_rd_addr", 32'(mem_read_addr), 32'(a));
        chk("issue_wr_addr", 32'(mem_write_addr), 32'(a));
        if (we) chk("issue_wr_data", 32'(mem_write_data), 32'(wd));

        k = 0;
        do begin
            @(negedge clk);
            k++;
            chk("resp_enables_low", 32'({mem_read_en, mem_write_en}), 32'(0));
        end while (!fetch_ack && !data_ack && k < 40);
        chk("ack_latency", 32'(k), 32'(exp_k));
        chk("fetch_ack", 32'(fetch_ack), 32'(!win));
        chk("data_ack", 32'(data_ack), 32'(win));
        got_data = data_ack;

        if (we) begin
            ref_mem[a] = wd;
        end else begin
            rd = timed_out ? '0 : ref_read(a);
            if (win) exp_drdata = rd;
            else     exp_fdata  = rd;
        end
        if (timed_out) exp_tmo = 1'b1;
        chk("fetch_data", 32'(fetch_data), 32'(exp_fdata));
        chk("data_rdata", 32'(data_rdata), 32'(exp_drdata));
        chk("timeout_flag", 32'(timeout), 32'(exp_tmo));

        if (!keep) begin
            if (win) data_req = 1'b0;
            else     fetch_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_one_cycle", 32'({fetch_ack, data_ack}), 32'(0));
        chk("idle_enables_low", 32'({mem_read_en, mem_write_en}), 32'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_en"}, 32'({mem_read_en, mem_write_en}), 32'(0));
        chk({tag, "_ack"}, 32'({fetch_ack, data_ack}), 32'(0));
        chk({tag, "_addr"}, 32'({mem_read_addr, mem_write_addr}), 32'(0));
        chk({tag, "_wdata"}, 32'(mem_write_data), 32'(0));
        chk({tag, "_fdata"}, 32'(fetch_data), 32'(0));
        chk({tag, "_drdata"}, 32'(data_rdata), 32'(0));
        chk({tag, "_timeout"}, 32'(timeout), 32'(0));
    endtask

    initial begin
        bit         g;
        logic [2:0] exp_seq;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Contention right after reset: pointer starts at fetch, data wins first
        exp_seq    = RR ? 3'b101 : 3'b111;
        fetch_addr = 16'h2000;
        data_addr  = 16'h2100;
        data_we    = 1'b0;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(1, 1'b1, g);
            chk("contention_winner", 32'(g), 32'(exp_seq[2-i]));
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(negedge clk);

        // Fetch-only read
        mem_store[16'h3000] = 16'h1234;
        ref_mem[16'h3000]   = 16'h1234;
        fetch_addr = 16'h3000;
        fetch_req  = 1'b1;
        serve(1, 1'b0, g);
        chk("fetch_0x3000", 32'(fetch_data), 32'h1234);

        // Store then load
        data_addr  = 16'h4000;
        data_wdata = 16'hBEEF;
        data_we    = 1'b1;
        data_req   = 1'b1;
        serve(1, 1'b0, g);
        data_we  = 1'b0;
        data_req = 1'b1;
        serve(1, 1'b0, g);
        chk("store_load_0x4000", 32'(data_rdata), 32'hBEEF);

        // Timeout boundary: ready on the last allowed cycle still succeeds
        fetch_addr = 16'h4000;
        fetch_req  = 1'b1;
        serve(15, 1'b0, g);
        chk("late_ready_no_timeout", 32'(timeout), 32'(0));
        fetch_req = 1'b1;
        serve(0, 1'b0, g);
        chk("timeout_set", 32'(timeout), 32'(1));
        chk("timeout_fdata_zero", 32'(fetch_data), 32'(0));
        data_addr = 16'h3000;
        data_req  = 1'b1;
        serve(16, 1'b0, g);
        chk("timeout_drdata_zero", 32'(data_rdata), 32'(0));
        fetch_req = 1'b1;
        serve(2, 1'b0, g);
        chk("timeout_sticky", 32'(timeout), 32'(1));

        // Randomized accesses over a small address pool
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind       = int'($urandom_range(0, 3));
            fetch_addr = 16'h0100 + 16'($urandom_range(0, 3));
            data_addr  = 16'h0100 + 16'($urandom_range(0, 3));
            data_wdata = 16'($urandom);
            data_we    = 1'($urandom_range(0, 1));
            case (kind)
                0: fetch_req = 1'b1;
                1: begin data_we = 1'b0; data_req = 1'b1; end
                2: begin data_we = 1'b1; data_req = 1'b1; end
                default: begin fetch_req = 1'b1; data_req = 1'b1; end
            endcase
            serve(int'($urandom_range(1, 4)), 1'b0, g);
            if (kind == 3) serve(int'($urandom_range(1, 4)), 1'b0, g);
        end

        // Reset during RESP abandons the access
        data_addr = 16'h4000;
        data_we   = 1'b0;
        data_req  = 1'b1;
        rsp_delay = 6;
        @(negedge clk);
        chk("pre_reset_issue", 32'(mem_read_en), 32'(1));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        data_req   = 1'b0;
        exp_fdata  = '0;
        exp_drdata = '0;
        exp_tmo    = 1'b0;
        last_gnt   = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack_after_reset", 32'({fetch_ack, data_ack}), 32'(0));
        end
        data_req = 1'b1;
        serve(1, 1'b0, g);
        chk("reissue_after_reset", 32'(data_rdata), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
